// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshake,
// sticky overflow status and a wrapping completed-operation counter.
module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         cmd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               cout,
    output logic               flag,
    output logic               zero,
    output logic               ovf_sticky,
    input  logic               sticky_clr,
    output logic [COUNT_W-1:0] op_count
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        CMD_ADD  = 3'b000,
        CMD_SUB  = 3'b001,
        CMD_XOR  = 3'b010,
        CMD_SLT  = 3'b011,
        CMD_AND  = 3'b100,
        CMD_NAND = 3'b101,
        CMD_NOR  = 3'b110,
        CMD_OR   = 3'b111
    } cmd_e;

    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         cmd_q, cmd_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               flag_q, flag_d;
    logic               zero_q, zero_d;
    logic               ovf_sticky_q, ovf_sticky_d;
    logic [COUNT_W-1:0] op_count_q, op_count_d;

    logic               s1_adv, s2_adv, out_hs;
    logic [WIDTH:0]     sum, diff;
    logic               ovf_add, ovf_sub;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cout, alu_flag;

    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
        ovf_add  = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
        ovf_sub  = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_flag = 1'b0;
        unique case (cmd_q)
            CMD_ADD: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_flag = ovf_add;
            end
            CMD_SUB: begin
                alu_res  = diff[WIDTH-1:0];
                alu_cout = diff[WIDTH];
                alu_flag = ovf_sub;
            end
            CMD_XOR:  alu_res = a_q ^ b_q;
            // signed less-than: sign of difference corrected by overflow
            CMD_SLT:  alu_res = {{(WIDTH-1){1'b0}}, diff[MSB] ^ ovf_sub};
            CMD_AND:  alu_res = a_q & b_q;
            CMD_NAND: alu_res = ~(a_q & b_q);
            CMD_NOR:  alu_res = ~(a_q | b_q);
            CMD_OR:   alu_res = a_q | b_q;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        s2_adv = !out_valid_q || out_ready;
        s1_adv = !s1_valid_q || s2_adv;
        out_hs = out_valid_q && out_ready;

        s1_valid_d   = s1_valid_q;
        a_d          = a_q;
        b_d          = b_q;
        cmd_d        = cmd_q;
        out_valid_d  = out_valid_q;
        result_d     = result_q;
        cout_d       = cout_q;
        flag_d       = flag_q;
        zero_d       = zero_q;
        op_count_d   = op_count_q;
        ovf_sticky_d = ovf_sticky_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                a_d   = a;
                b_d   = b;
                cmd_d = cmd;
            end
        end
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = alu_res;
                cout_d   = alu_cout;
                flag_d   = alu_flag;
                zero_d   = (alu_res == '0);
            end
        end
        if (out_hs) begin
            op_count_d = op_count_q + COUNT_W'(1);
        end
        // a set on this handshake outranks a simultaneous clear
        if (out_hs && flag_q) begin
            ovf_sticky_d = 1'b1;
        end else if (sticky_clr) begin
            ovf_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            cmd_q        <= '0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            cout_q       <= 1'b0;
            flag_q       <= 1'b0;
            zero_q       <= 1'b0;
            ovf_sticky_q <= 1'b0;
            op_count_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cmd_q        <= cmd_d;
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            cout_q       <= cout_d;
            flag_q       <= flag_d;
            zero_q       <= zero_d;
            ovf_sticky_q <= ovf_sticky_d;
            op_count_q   <= op_count_d;
        end
    end

    assign in_ready   = s1_adv;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign cout       = cout_q;
    assign flag       = flag_q;
    assign zero       = zero_q;
    assign ovf_sticky = ovf_sticky_q;
    assign op_count   = op_count_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized and directed checks of alu_pipe against an
// arithmetic reference model and an in-order expected-result queue.
module tb_alu_pipe;
    typedef struct {
        logic [31:0] res;
        logic        cout;
        logic        flag;
        logic        zero;
    } exp_t;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, SLT = 3'd3;
    localparam logic [2:0] NAND = 3'd5, NOR = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] a = '0, b = '0;
    logic [2:0]  cmd = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] result;
    logic        cout, flag, zero, ovf_sticky;
    logic        sticky_clr = 1'b0;
    logic [15:0] op_count;

    logic        in_valid8 = 1'b0, in_ready8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [2:0]  cmd8 = '0;
    logic        out_valid8, out_ready8 = 1'b0;
    logic [7:0]  result8;
    logic        cout8, flag8, zero8, ovf_sticky8;
    logic [2:0]  op_count8;

    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    logic [15:0] m_cnt = '0;
    logic        m_sticky = 1'b0;

    alu_pipe #(.WIDTH(32), .COUNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cmd(cmd),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .flag(flag), .zero(zero),
        .ovf_sticky(ovf_sticky), .sticky_clr(sticky_clr),
        .op_count(op_count)
    );

    alu_pipe #(.WIDTH(8), .COUNT_W(3)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cmd(cmd8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .cout(cout8), .flag(flag8), .zero(zero8),
        .ovf_sticky(ovf_sticky8), .sticky_clr(1'b0),
        .op_count(op_count8)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_alu(input int w, input longint x,
                                     input longint y, input int op);
        longint mask, half, sx, sy, r, s;
        exp_t   e;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sx = (x >= half) ? x - (mask + 1) : x;
        sy = (y >= half) ? y - (mask + 1) : y;
        e.cout = 1'b0;
        e.flag = 1'b0;
        s = 0;
        case (op)
            0: begin
                r = (x + y) & mask;
                e.cout = (x + y) > mask;
                s = sx + sy;
                e.flag = (s >= half) || (s < -half);
            end
            1: begin
                r = (x - y) & mask;
                e.cout = (x >= y);
                s = sx - sy;
                e.flag = (s >= half) || (s < -half);
            end
            2: r = x ^ y;
            3: r = (sx < sy) ? 1 : 0;
            4: r = x & y;
            5: r = ~(x & y) & mask;
            6: r = ~(x | y) & mask;
            default: r = x | y;
        endcase
        e.res  = 32'(r);
        e.zero = (r == 0);
        return e;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic cyc(input logic iv, input logic [31:0] ia,
                       input logic [31:0] ib, input logic [2:0] ic,
                       input logic ordy, input logic clr,
                       output logic acc);
        exp_t e;
        logic ohs;
        in_valid = iv; a = ia; b = ib; cmd = ic;
        out_ready = ordy; sticky_clr = clr;
        #1;
        acc = iv && in_ready;
        ohs = out_valid && ordy;
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out", out_valid, 1'b0);
            end else begin
                chk("result", result, sb[0].res);
                chk("cout", cout, sb[0].cout);
                chk("flag", flag, sb[0].flag);
                chk("zero", zero, sb[0].zero);
            end
        end
        if (ohs && sb.size() > 0) begin
            e = sb.pop_front();
            m_cnt++;
            if (e.flag) m_sticky = 1'b1;
            else if (clr) m_sticky = 1'b0;
        end else if (clr) begin
            m_sticky = 1'b0;
        end
        if (acc) sb.push_back(ref_alu(32, longint'(ia), longint'(ib), int'(ic)));
        @(posedge clk);
        @(negedge clk);
        chk("ovf_sticky", ovf_sticky, m_sticky);
        chk("op_count", op_count, m_cnt);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_result", result, 32'h0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_flag", flag, 1'b0);
        chk("rst_zero", zero, 1'b0);
        chk("rst_sticky", ovf_sticky, 1'b0);
        chk("rst_op_count", op_count, 16'h0);
        chk("rst_out_valid8", out_valid8, 1'b0);
        sb.delete();
        m_cnt = '0;
        m_sticky = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic dir32(input string tag, input logic [31:0] ia,
                         input logic [31:0] ib, input logic [2:0] ic,
                         input logic [31:0] er, input logic ec,
                         input logic ef, input logic clr);
        logic acc;
        cyc(1'b1, ia, ib, ic, 1'b1, 1'b0, acc);
        chk({tag, "_acc"}, acc, 1'b1);
        chk({tag, "_lat1"}, out_valid, 1'b0);
        cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, acc);
        chk({tag, "_lat2"}, out_valid, 1'b1);
        chk({tag, "_res"}, result, er);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_flag"}, flag, ef);
        chk({tag, "_zero"}, zero, er == 32'h0);
        cyc(1'b0, '0, '0, '0, 1'b1, clr, acc);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && sb.size() > 0; i++)
            cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
        chk("drain", sb.size(), 0);
    endtask

    task automatic run8(input logic [7:0] ia, input logic [7:0] ib,
                        input logic [2:0] ic, input logic [7:0] er,
                        input logic ec, input logic ef);
        a8 = ia; b8 = ib; cmd8 = ic;
        in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid8 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("w8_valid", out_valid8, 1'b1);
        chk("w8_res", result8, er);
        chk("w8_cout", cout8, ec);
        chk("w8_flag", flag8, ef);
        chk("w8_zero", zero8, er == 8'h0);
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        logic [31:0] ops_a[4], ops_b[4];
        logic [2:0]  ops_c[4];
        logic [31:0] ra, rb;
        logic [2:0]  rc;
        logic        acc;
        int          k;
        exp_t        e8;

        #2;
        do_reset();

        dir32("add_ovf", 32'h7FFF_FFFF, 32'h1, ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        chk("sticky_set", ovf_sticky, 1'b1);
        dir32("sub_eq", 32'd5, 32'd5, SUB, 32'h0, 1'b1, 1'b0, 1'b0);
        dir32("sub_brw", 32'd0, 32'd1, SUB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        dir32("slt_neg", 32'hFFFF_FFFF, 32'd1, SLT, 32'h1, 1'b0, 1'b0, 1'b0);
        dir32("slt_pos", 32'd1, 32'hFFFF_FFFF, SLT, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b1, acc);
        chk("sticky_clr", ovf_sticky, 1'b0);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            ops_a[i] = $urandom; ops_b[i] = $urandom;
            ops_c[i] = 3'($urandom_range(0, 7));
        end
        k = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, ops_a[k], ops_b[k], ops_c[k], 1'b0, 1'b0, acc);
            if (acc) k++;
        end
        chk("bp_accepted", k, 2);
        chk("bp_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_follow", in_ready, 1'b1);
        for (int i = 0; i < 12 && k < 4; i++) begin
            cyc(1'b1, ops_a[k], ops_b[k], ops_c[k], 1'b1, 1'b0, acc);
            if (acc) k++;
        end
        chk("bp_all_acc", k, 4);
        drain();
        chk("bp_op_count", op_count, 16'd4);

        for (int i = 0; i < 400; i++) begin
            ra = rnd_op(); rb = rnd_op();
            rc = 3'($urandom_range(0, 7));
            cyc($urandom_range(0, 3) != 0, ra, rb, rc,
                $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, acc);
        end
        drain();

        dir32("pre_rst", 32'h8000_0000, 32'h8000_0000, ADD, 32'h0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 32'd3, 32'd4, ADD, 1'b0, 1'b0, acc);
        cyc(1'b1, 32'd5, 32'd6, SUB, 1'b0, 1'b0, acc);
        do_reset();
        dir32("set_clr", 32'h7FFF_FFFF, 32'h1, ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        chk("set_wins", ovf_sticky, 1'b1);
        drain();

        run8(8'hFF, 8'h01, ADD, 8'h00, 1'b1, 1'b0);
        run8(8'hF0, 8'hFF, NAND, 8'h0F, 1'b0, 1'b0);
        run8(8'h0F, 8'hF0, NOR, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ra = 32'($urandom_range(0, 255));
            rb = 32'($urandom_range(0, 255));
            rc = 3'($urandom_range(0, 7));
            e8 = ref_alu(8, longint'(ra), longint'(rb), int'(rc));
            run8(ra[7:0], rb[7:0], rc, e8.res[7:0], e8.cout, e8.flag);
        end
        chk("w8_cnt_wrap", op_count8, 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
